// File: rtl/jpeg_enc_pkg.sv
// Shared JPEG entropy-prep definitions: symbol layout, special symbols and
// the arithmetic helpers used to turn coefficients into (size, amplitude).
package jpeg_enc_pkg;

  localparam int SYM_W        = 24;
  localparam int SYM_DC_BIT   = 23;
  localparam int SYM_COMP_LSB = 21;
  localparam int SYM_RUN_LSB  = 17;
  localparam int SYM_SIZE_LSB = 13;
  localparam int AMP_W        = 11;

  localparam logic [3:0] ZRL_RUN = 4'd15;
  localparam logic [3:0] EOB_RUN = 4'd0;

  localparam logic signed [15:0] COEF_MAX = 16'sd1023;
  localparam logic signed [11:0] DIFF_MAX = 12'sd2047;

  // Clamp a raw 16-bit coefficient to [-1023, 1023].
  function automatic logic signed [10:0] sat_coef(input logic signed [15:0] x);
    if (x > COEF_MAX) return 11'sd1023;
    else if (x < -COEF_MAX) return -11'sd1023;
    else return x[10:0];
  endfunction

  // Clamp a 12-bit DC difference to [-2047, 2047].
  function automatic logic signed [11:0] sat_diff(input logic signed [11:0] x);
    if (x < -DIFF_MAX) return -DIFF_MAX;
    else return x;
  endfunction

  // Absolute value of an already-saturated 12-bit value.
  function automatic logic [10:0] magnitude(input logic signed [11:0] v);
    logic [11:0] m;
    m = v[11] ? 12'(-v) : v;
    return 11'(m);
  endfunction

  // Bit length of a magnitude; 0 only for a zero magnitude.
  function automatic logic [3:0] bit_size(input logic [10:0] mag);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 11; i++) begin
      if (mag[i]) s = 4'(i + 1);
    end
    return s;
  endfunction

  // JPEG amplitude bits: negatives become (v - 1) truncated to size bits.
  function automatic logic [AMP_W-1:0] amp_encode(input logic signed [11:0] v,
                                                  input logic [3:0] size);
    logic [12:0] t;
    logic [12:0] mask;
    t    = v[11] ? ({v[11], v} - 13'd1) : {v[11], v};
    mask = (13'd1 << size) - 13'd1;
    return 11'(t & mask);
  endfunction

  // Pack one output symbol; the two-bit zero field stays clear.
  function automatic logic [SYM_W-1:0] make_sym(input logic dc,
                                                input logic [1:0] comp,
                                                input logic [3:0] run,
                                                input logic [3:0] size,
                                                input logic [AMP_W-1:0] amp);
    logic [SYM_W-1:0] s;
    s = '0;
    s[SYM_DC_BIT]           = dc;
    s[SYM_COMP_LSB +: 2]    = comp;
    s[SYM_RUN_LSB +: 4]     = run;
    s[SYM_SIZE_LSB +: 4]    = size;
    s[0 +: AMP_W]           = amp;
    return s;
  endfunction

endpackage

// File: rtl/run_length_encoder.sv
// Run-length encoder: zigzag coefficients in, JPEG DC/AC/ZRL/EOB symbols out
// through a single registered output stage, with a DC predictor per component.
module run_length_encoder
  import jpeg_enc_pkg::*;
#(
  parameter int NUM_COMP = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [15:0] s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic               s_axis_tlast,
  input  logic               s_axis_tuser,
  output logic [23:0]        m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast,
  output logic               m_axis_tuser
);

  localparam logic [0:0] ST_ACCEPT = 1'b0;
  localparam logic [0:0] ST_ZRL    = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [5:0]        coef_idx_q, coef_idx_d;
  logic [1:0]        comp_q, comp_d;
  logic [5:0]        zero_run_q, zero_run_d;
  logic signed [10:0] pred_q [NUM_COMP];
  logic signed [10:0] pred_d [NUM_COMP];
  logic [3:0]        held_size_q, held_size_d;
  logic [AMP_W-1:0]  held_amp_q, held_amp_d;
  logic [1:0]        held_comp_q, held_comp_d;
  logic              held_last_q, held_last_d;
  logic [SYM_W-1:0]  out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              out_user_q, out_user_d;

  logic              out_free, fire, sof, idx_last;
  logic [1:0]        comp_eff;
  logic signed [10:0] coef, pred_cur;
  logic signed [11:0] coef_x, diff;
  logic [3:0]        coef_size, dc_size;
  logic [AMP_W-1:0]  coef_amp, dc_amp;

  assign out_free      = !out_valid_q || m_axis_tready;
  assign s_axis_tready = (state_q == ST_ACCEPT) && out_free;
  assign fire          = s_axis_tvalid && s_axis_tready;
  assign idx_last      = (coef_idx_q == 6'd63);
  assign sof           = (coef_idx_q == 6'd0) && s_axis_tuser;
  assign comp_eff      = sof ? 2'd0 : comp_q;

  assign coef      = sat_coef(s_axis_tdata);
  assign coef_x    = {coef[10], coef};
  assign coef_size = bit_size(magnitude(coef_x));
  assign coef_amp  = amp_encode(coef_x, coef_size);

  // Predictor of the current component; a start of frame forces it to zero.
  always_comb begin
    pred_cur = '0;
    if (!sof) begin
      for (int i = 0; i < NUM_COMP; i++) begin
        if (comp_eff == 2'(i)) pred_cur = pred_q[i];
      end
    end
  end

  assign diff    = sat_diff(coef_x - {pred_cur[10], pred_cur});
  assign dc_size = bit_size(magnitude(diff));
  assign dc_amp  = amp_encode(diff, dc_size);

  // Next-state logic: coefficient acceptance, ZRL sequencing, output register.
  always_comb begin
    state_d     = state_q;
    coef_idx_d  = coef_idx_q;
    comp_d      = comp_q;
    zero_run_d  = zero_run_q;
    pred_d      = pred_q;
    held_size_d = held_size_q;
    held_amp_d  = held_amp_q;
    held_comp_d = held_comp_q;
    held_last_d = held_last_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !m_axis_tready;
    out_last_d  = out_last_q;
    out_user_d  = out_user_q;

    if (state_q == ST_ACCEPT) begin
      if (fire) begin
        coef_idx_d = coef_idx_q + 6'd1;
        if (idx_last) comp_d = (comp_eff == 2'(NUM_COMP - 1)) ? 2'd0 : comp_eff + 2'd1;
        else          comp_d = comp_eff;
        if (sof) begin
          for (int i = 0; i < NUM_COMP; i++) pred_d[i] = '0;
        end
        if (coef_idx_q == 6'd0) begin
          for (int i = 0; i < NUM_COMP; i++) begin
            if (comp_eff == 2'(i)) pred_d[i] = coef;
          end
          zero_run_d  = '0;
          out_valid_d = 1'b1;
          out_data_d  = make_sym(1'b1, comp_eff, 4'd0, dc_size, dc_amp);
          out_last_d  = 1'b0;
          out_user_d  = s_axis_tuser;
        end else if (coef == '0) begin
          if (idx_last) begin
            zero_run_d  = '0;
            out_valid_d = 1'b1;
            out_data_d  = make_sym(1'b0, comp_q, EOB_RUN, 4'd0, '0);
            out_last_d  = s_axis_tlast;
            out_user_d  = 1'b0;
          end else begin
            zero_run_d = zero_run_q + 6'd1;
          end
        end else if (zero_run_q < 6'd16) begin
          zero_run_d  = '0;
          out_valid_d = 1'b1;
          out_data_d  = make_sym(1'b0, comp_q, zero_run_q[3:0], coef_size, coef_amp);
          out_last_d  = idx_last && s_axis_tlast;
          out_user_d  = 1'b0;
        end else begin
          // Too many pending zeros: emit one ZRL now, park the coefficient.
          zero_run_d  = zero_run_q - 6'd16;
          held_size_d = coef_size;
          held_amp_d  = coef_amp;
          held_comp_d = comp_q;
          held_last_d = idx_last && s_axis_tlast;
          state_d     = ST_ZRL;
          out_valid_d = 1'b1;
          out_data_d  = make_sym(1'b0, comp_q, ZRL_RUN, 4'd0, '0);
          out_last_d  = 1'b0;
          out_user_d  = 1'b0;
        end
      end
    end else if (out_free) begin
      out_valid_d = 1'b1;
      out_user_d  = 1'b0;
      if (zero_run_q >= 6'd16) begin
        zero_run_d = zero_run_q - 6'd16;
        out_data_d = make_sym(1'b0, held_comp_q, ZRL_RUN, 4'd0, '0);
        out_last_d = 1'b0;
      end else begin
        zero_run_d = '0;
        out_data_d = make_sym(1'b0, held_comp_q, zero_run_q[3:0], held_size_q, held_amp_q);
        out_last_d = held_last_q;
        state_d    = ST_ACCEPT;
      end
    end
  end

  // State, counters, predictors and the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACCEPT;
      coef_idx_q  <= '0;
      comp_q      <= '0;
      zero_run_q  <= '0;
      for (int i = 0; i < NUM_COMP; i++) pred_q[i] <= '0;
      held_size_q <= '0;
      held_amp_q  <= '0;
      held_comp_q <= '0;
      held_last_q <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_user_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      coef_idx_q  <= coef_idx_d;
      comp_q      <= comp_d;
      zero_run_q  <= zero_run_d;
      pred_q      <= pred_d;
      held_size_q <= held_size_d;
      held_amp_q  <= held_amp_d;
      held_comp_q <= held_comp_d;
      held_last_q <= held_last_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_user_q  <= out_user_d;
    end
  end

  assign m_axis_tdata  = out_data_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tlast  = out_last_q;
  assign m_axis_tuser  = out_user_q;

endmodule
